// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the I/D cache memory arbiter: FSM state encodings and requester IDs.
package mem_arbiter_pkg;

    localparam logic [1:0] ARB_IDLE   = 2'd0;
    localparam logic [1:0] ARB_BUSY_I = 2'd1;
    localparam logic [1:0] ARB_BUSY_D = 2'd2;
    localparam logic [1:0] ARB_DONE   = 2'd3;

    localparam logic REQ_I = 1'b0;
    localparam logic REQ_D = 1'b1;

endpackage

// File: rtl/mem_arbiter_pick.sv
// Combinational two-requester picker. With MEM_ARB_RR_EN the pointer names the
// preferred requester under contention; otherwise the D-cache always wins.
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       i_valid,
    input  logic       d_valid,
`ifdef MEM_ARB_RR_EN
    input  logic       ptr,
`endif
    output logic [1:0] grant
);

    // One-hot grant indexed by requester ID
    always_comb begin
        grant = 2'b00;
        if (i_valid && d_valid) begin
`ifdef MEM_ARB_RR_EN
            grant[ptr] = 1'b1;
`else
            grant[REQ_D] = 1'b1;
`endif
        end else if (d_valid) begin
            grant[REQ_D] = 1'b1;
        end else if (i_valid) begin
            grant[REQ_I] = 1'b1;
        end else begin
            grant = 2'b00;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// I-cache / D-cache arbiter onto a single memory port. Optional round-robin
// arbitration is compiled in with MEM_ARB_RR_EN (fixed D priority otherwise).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic              i_req_valid,
    output logic [DATA_W-1:0] i_rsp_data,
    output logic              i_rsp_ready,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic              d_req_wr,
    input  logic [DATA_W-1:0] d_req_wdata,
    input  logic              d_req_valid,
    output logic [DATA_W-1:0] d_rsp_data,
    output logic              d_rsp_ready,
    output logic [ADDR_W-1:0] mem_req_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    output logic              mem_req_wr,
    output logic              mem_req_valid,
    input  logic [DATA_W-1:0] mem_req_data,
    input  logic              mem_req_ready
);

    logic [1:0] state_r;
    logic [1:0] grant_s;

`ifdef MEM_ARB_RR_EN
    logic rr_ptr_r;

    arb_pick u_pick (
        .i_valid (i_req_valid),
        .d_valid (d_req_valid),
        .ptr     (rr_ptr_r),
        .grant   (grant_s)
    );

    // Preference flips to the requester that was not just granted
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_r <= REQ_I;
        end else if (state_r == ARB_IDLE && grant_s != 2'b00) begin
            rr_ptr_r <= grant_s[REQ_I] ? REQ_D : REQ_I;
        end else begin
            rr_ptr_r <= rr_ptr_r;
        end
    end
`else
    arb_pick u_pick (
        .i_valid (i_req_valid),
        .d_valid (d_req_valid),
        .grant   (grant_s)
    );
`endif

    // Arbitration FSM: launch, hold the bus until memory handshakes, pulse ready once
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r       <= ARB_IDLE;
            mem_req_addr  <= {ADDR_W{1'b0}};
            mem_wr_data   <= {DATA_W{1'b0}};
            mem_req_wr    <= 1'b0;
            mem_req_valid <= 1'b0;
            i_rsp_data    <= {DATA_W{1'b0}};
            i_rsp_ready   <= 1'b0;
            d_rsp_data    <= {DATA_W{1'b0}};
            d_rsp_ready   <= 1'b0;
        end else begin
            case (state_r)
                ARB_IDLE: begin
                    i_rsp_ready <= 1'b0;
                    d_rsp_ready <= 1'b0;
                    if (grant_s[REQ_D]) begin
                        mem_req_addr  <= d_req_addr;
                        mem_req_wr    <= d_req_wr;
                        mem_wr_data   <= d_req_wdata;
                        mem_req_valid <= 1'b1;
                        state_r       <= ARB_BUSY_D;
                    end else if (grant_s[REQ_I]) begin
                        mem_req_addr  <= i_req_addr;
                        mem_req_wr    <= 1'b0;
                        mem_wr_data   <= {DATA_W{1'b0}};
                        mem_req_valid <= 1'b1;
                        state_r       <= ARB_BUSY_I;
                    end else begin
                        state_r <= ARB_IDLE;
                    end
                end
                ARB_BUSY_I: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        i_rsp_data    <= mem_req_data;
                        i_rsp_ready   <= 1'b1;
                        state_r       <= ARB_DONE;
                    end else begin
                        state_r <= ARB_BUSY_I;
                    end
                end
                ARB_BUSY_D: begin
                    if (mem_req_ready) begin
                        mem_req_valid <= 1'b0;
                        if (!mem_req_wr) begin
                            d_rsp_data <= mem_req_data;
                        end else begin
                            d_rsp_data <= d_rsp_data;
                        end
                        d_rsp_ready <= 1'b1;
                        state_r     <= ARB_DONE;
                    end else begin
                        state_r <= ARB_BUSY_D;
                    end
                end
                ARB_DONE: begin
                    // No arbitration here: the requester gets a cycle to drop valid
                    i_rsp_ready <= 1'b0;
                    d_rsp_ready <= 1'b0;
                    state_r     <= ARB_IDLE;
                end
                default: begin
                    i_rsp_ready   <= 1'b0;
                    d_rsp_ready   <= 1'b0;
                    mem_req_valid <= 1'b0;
                    state_r       <= ARB_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: transaction-level reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] i_req_addr = 32'h0;
    logic        i_req_valid = 1'b0;
    logic [31:0] i_rsp_data;
    logic        i_rsp_ready;
    logic [31:0] d_req_addr = 32'h0;
    logic        d_req_wr = 1'b0;
    logic [31:0] d_req_wdata = 32'h0;
    logic        d_req_valid = 1'b0;
    logic [31:0] d_rsp_data;
    logic        d_rsp_ready;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_wr_data;
    logic        mem_req_wr;
    logic        mem_req_valid;
    logic [31:0] mem_req_data = 32'h0;
    logic        mem_req_ready = 1'b0;

    int pass_cnt = 0;
    int total_cnt = 0;
    int i_pulses = 0;
    int d_pulses = 0;

    mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_req_addr    (i_req_addr),
        .i_req_valid   (i_req_valid),
        .i_rsp_data    (i_rsp_data),
        .i_rsp_ready   (i_rsp_ready),
        .d_req_addr    (d_req_addr),
        .d_req_wr      (d_req_wr),
        .d_req_wdata   (d_req_wdata),
        .d_req_valid   (d_req_valid),
        .d_rsp_data    (d_rsp_data),
        .d_rsp_ready   (d_rsp_ready),
        .mem_req_addr  (mem_req_addr),
        .mem_wr_data   (mem_wr_data),
        .mem_req_wr    (mem_req_wr),
        .mem_req_valid (mem_req_valid),
        .mem_req_data  (mem_req_data),
        .mem_req_ready (mem_req_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Reference model: who owns the bus, and whether we are in the post-completion gap
    int          m_owner = 0;       // 0 none, 1 I-cache, 2 D-cache
    bit          m_gap = 1'b0;
    bit          m_pref_d = 1'b0;   // round-robin preference
    bit          pick_d;
    logic [31:0] e_addr = 32'h0, e_wdata = 32'h0, e_i_data = 32'h0, e_d_data = 32'h0;
    logic        e_wr = 1'b0, e_valid = 1'b0, e_i_rdy = 1'b0, e_d_rdy = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner = 0; m_gap = 1'b0; m_pref_d = 1'b0;
            e_addr = 32'h0; e_wdata = 32'h0; e_i_data = 32'h0; e_d_data = 32'h0;
            e_wr = 1'b0; e_valid = 1'b0; e_i_rdy = 1'b0; e_d_rdy = 1'b0;
        end else begin
            e_i_rdy = 1'b0;
            e_d_rdy = 1'b0;
            if (m_owner != 0) begin
                if (mem_req_ready) begin
                    e_valid = 1'b0;
                    if (m_owner == 1) begin
                        e_i_data = mem_req_data;
                        e_i_rdy = 1'b1;
                    end else begin
                        if (!e_wr) e_d_data = mem_req_data;
                        e_d_rdy = 1'b1;
                    end
                    m_owner = 0;
                    m_gap = 1'b1;
                end
            end else if (m_gap) begin
                m_gap = 1'b0;
            end else if (i_req_valid || d_req_valid) begin
`ifdef MEM_ARB_RR_EN
                pick_d = d_req_valid && (!i_req_valid || m_pref_d);
                m_pref_d = !pick_d;
`else
                pick_d = d_req_valid;
`endif
                e_valid = 1'b1;
                if (pick_d) begin
                    m_owner = 2; e_addr = d_req_addr; e_wr = d_req_wr; e_wdata = d_req_wdata;
                end else begin
                    m_owner = 1; e_addr = i_req_addr; e_wr = 1'b0; e_wdata = 32'h0;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("bus", 128'({mem_req_valid, mem_req_wr, mem_req_addr, mem_wr_data}),
                     128'({e_valid, e_wr, e_addr, e_wdata}));
        check("i_rsp", 128'({i_rsp_ready, i_rsp_data}), 128'({e_i_rdy, e_i_data}));
        check("d_rsp", 128'({d_rsp_ready, d_rsp_data}), 128'({e_d_rdy, e_d_data}));
        if (i_rsp_ready) i_pulses++;
        if (d_rsp_ready) d_pulses++;
    end

    // Returns #1 after the edge on which mem_req_valid is first seen; w = edges waited
    task automatic wait_grant(output int w);
        w = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (mem_req_valid) begin
                w = k;
                break;
            end
        end
        if (w == 0) begin
            total_cnt++;
            $display("FAIL grant_timeout: got no mem_req_valid expected one within 40 cycles");
        end
    endtask

    // Memory handshake sampled 'cyc' edges after the grant edge; returns #1 after it
    task automatic mem_ack(input int cyc, input logic [31:0] data);
        repeat (cyc - 1) @(posedge clk);
        #1;
        mem_req_ready = 1'b1;
        mem_req_data  = data;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
    endtask

    int w, i_snap, d_snap;
    logic [31:0] first_addr, exp_first;
    logic [31:0] grant_addr [4];
    logic [31:0] exp_order [4];

    initial begin
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outs", 128'({mem_req_valid, mem_req_wr, mem_req_addr, mem_wr_data,
                                  i_rsp_ready, d_rsp_ready}), 128'(0));
        check("reset_rsp_data", 128'({i_rsp_data, d_rsp_data}), 128'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // 1: I-only read
        i_snap = i_pulses; d_snap = d_pulses;
        i_req_addr = 32'h0000_0040; i_req_valid = 1'b1;
        wait_grant(w);
        check("t1_latency", 128'(w), 128'(1));
        check("t1_bus", 128'({mem_req_addr, mem_req_wr}), 128'({32'h40, 1'b0}));
        mem_ack(3, 32'hDEAD_BEEF);
        check("t1_ready", 128'({i_rsp_ready, d_rsp_ready}), 128'(2'b10));
        i_req_valid = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("t1_data", 128'(i_rsp_data), 128'(32'hDEAD_BEEF));
        check("t1_pulses", 128'({i_pulses - i_snap, d_pulses - d_snap}), 128'({32'd1, 32'd0}));

        // 2: D writeback, data must not be captured into d_rsp_data
        d_snap = d_pulses;
        d_req_addr = 32'h0000_1230; d_req_wdata = 32'h1234_5678; d_req_wr = 1'b1; d_req_valid = 1'b1;
        wait_grant(w);
        check("t2_bus", 128'({mem_req_addr, mem_req_wr, mem_wr_data}),
                        128'({32'h1230, 1'b1, 32'h1234_5678}));
        mem_ack(4, 32'hFFFF_0000);
        check("t2_ready", 128'({i_rsp_ready, d_rsp_ready}), 128'(2'b01));
        d_req_valid = 1'b0; d_req_wr = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("t2_rsp_data_kept", 128'(d_rsp_data), 128'(0));
        check("t2_pulses", 128'(d_pulses - d_snap), 128'(1));

        // 3: simultaneous requests
        i_req_addr = 32'h40; d_req_addr = 32'h2000; i_req_valid = 1'b1; d_req_valid = 1'b1;
`ifdef MEM_ARB_RR_EN
        exp_first = 32'h40;
`else
        exp_first = 32'h2000;
`endif
        wait_grant(w);
        first_addr = mem_req_addr;
        check("t3_first", 128'(first_addr), 128'(exp_first));
        mem_ack(2, 32'hA1A1_A1A1);
        if (first_addr == 32'h40) i_req_valid = 1'b0;
        else d_req_valid = 1'b0;
        wait_grant(w);
        check("t3_second_gap", 128'(w), 128'(2));
        check("t3_second", 128'(mem_req_addr), 128'(exp_first == 32'h40 ? 32'h2000 : 32'h40));
        mem_ack(2, 32'hB2B2_B2B2);
        i_req_valid = 1'b0; d_req_valid = 1'b0;
        repeat (3) @(posedge clk); #1;

        // 4: continuous contention for four transactions
        i_req_addr = 32'h40; d_req_addr = 32'h3000; i_req_valid = 1'b1; d_req_valid = 1'b1;
        for (int t = 0; t < 4; t++) begin
            wait_grant(w);
            grant_addr[t] = mem_req_addr;
            mem_ack(1, 32'h100 + 32'(t));
        end
        i_req_valid = 1'b0; d_req_valid = 1'b0;
`ifdef MEM_ARB_RR_EN
        exp_order[0] = 32'h40; exp_order[1] = 32'h3000; exp_order[2] = 32'h40; exp_order[3] = 32'h3000;
`else
        exp_order[0] = 32'h3000; exp_order[1] = 32'h3000; exp_order[2] = 32'h3000; exp_order[3] = 32'h3000;
`endif
        for (int t = 0; t < 4; t++) check($sformatf("t4_grant%0d", t), 128'(grant_addr[t]), 128'(exp_order[t]));
        repeat (3) @(posedge clk); #1;

        // 5: reset mid-BUSY clears outputs without waiting for a clock edge
        i_snap = i_pulses; d_snap = d_pulses;
        i_req_addr = 32'h80; i_req_valid = 1'b1;
        wait_grant(w);
        i_req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("t5_async_clear", 128'({mem_req_valid, mem_req_wr, mem_req_addr, mem_wr_data,
                                      i_rsp_ready, d_rsp_ready, i_rsp_data, d_rsp_data}), 128'(0));
        @(posedge clk); #1;
        rst = 1'b0;
        mem_req_ready = 1'b1;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        repeat (3) @(posedge clk); #1;
        check("t5_no_pulse", 128'({i_pulses - i_snap, d_pulses - d_snap, 31'd0, mem_req_valid}), 128'(0));

        // 6: requester drops valid during BUSY, then a stray ready arrives in IDLE
        d_snap = d_pulses;
        d_req_addr = 32'h5000; d_req_wr = 1'b0; d_req_valid = 1'b1;
        wait_grant(w);
        check("t6_idle_after_reset", 128'(w), 128'(1));
        d_req_valid = 1'b0;
        mem_ack(3, 32'hCAFE_F00D);
        check("t6_ready", 128'({d_rsp_ready, d_rsp_data}), 128'({1'b1, 32'hCAFE_F00D}));
        @(posedge clk); #1;
        mem_req_ready = 1'b1; mem_req_data = 32'h55;
        @(posedge clk); #1;
        mem_req_ready = 1'b0;
        check("t6_stray_ready", 128'({mem_req_valid, i_rsp_ready, d_rsp_ready, d_rsp_data}),
                                128'({3'b000, 32'hCAFE_F00D}));
        repeat (2) @(posedge clk); #1;
        check("t6_pulses", 128'(d_pulses - d_snap), 128'(1));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
